multicycle_control_unit: RTL and testbench



---
 rtl/multicycle_control_unit_if.sv | 37 +++
 rtl/multicycle_control_unit.sv | 190 +++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_unit_if.sv
// Control-unit bus: instruction word and memory handshake in, datapath strobes,
// decoded controls and retired count out.
interface multicycle_control_unit_if #(
    parameter int unsigned CNT_W = 32
);
    logic [31:0]      iInst_Code;
    logic             iMem_Ready;
    logic             oIR_En;
    logic             oPC_En;
    logic [2:0]       oFunct3;
    logic [3:0]       oALU_Control;
    logic [1:0]       oRegWrDataSel;
    logic             oALUSrcMuxSel1;
    logic             oALUSrcMuxSel2;
    logic             oWrEn;
    logic             oData_WrEn;
    logic             oData_RdEn;
    logic             oBranch;
    logic             oJal;
    logic             oJalr;
    logic             oIllegal;
    logic [CNT_W-1:0] oRetired;

    modport master (
        input  iInst_Code, iMem_Ready,
        output oIR_En, oPC_En, oFunct3, oALU_Control, oRegWrDataSel,
               oALUSrcMuxSel1, oALUSrcMuxSel2, oWrEn, oData_WrEn, oData_RdEn,
               oBranch, oJal, oJalr, oIllegal, oRetired
    );

    modport slave (
        output iInst_Code, iMem_Ready,
        input  oIR_En, oPC_En, oFunct3, oALU_Control, oRegWrDataSel,
               oALUSrcMuxSel1, oALUSrcMuxSel2, oWrEn, oData_WrEn, oData_RdEn,
               oBranch, oJal, oJalr, oIllegal, oRetired
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control FSM (FETCH/DECODE/EXE/MEM/WB/TRAP) with registered
// control outputs, sticky illegal flag and a retired-instruction counter.
module multicycle_control_unit #(
    parameter int          JUMP_EN       = 1,
    parameter int          MEM_HANDSHAKE = 1,
    parameter int unsigned CNT_W         = 32
) (
    input  logic iClk,
    input  logic iRst,
    multicycle_control_unit_if.master bus
);

    typedef enum logic [2:0] {FETCH, DECODE, EXE, MEM, WB, TRAP} stateT;

    typedef enum logic [3:0] {
        CLS_R, CLS_I, CLS_IL, CLS_S, CLS_B, CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_BAD
    } instClassT;

    typedef struct packed {
        logic       f7b5;
        logic [2:0] f3;
        logic [6:0] opcode;
    } irFieldsT;

    typedef struct packed {
        logic       irEn;
        logic       pcEn;
        logic [3:0] aluControl;
        logic [1:0] regWrDataSel;
        logic       aluSrc1;
        logic       aluSrc2;
        logic       wrEn;
        logic       dataWrEn;
        logic       dataRdEn;
        logic       branch;
        logic       jal;
        logic       jalr;
    } ctrlT;

    function automatic instClassT classify(input logic [6:0] opcode);
        instClassT c;
        case (opcode)
            7'b0110011: c = CLS_R;
            7'b0010011: c = CLS_I;
            7'b0000011: c = CLS_IL;
            7'b0100011: c = CLS_S;
            7'b1100011: c = CLS_B;
            7'b0110111: c = CLS_LUI;
            7'b0010111: c = CLS_AUIPC;
            7'b1101111: c = (JUMP_EN != 0) ? CLS_JAL : CLS_BAD;
            7'b1100111: c = (JUMP_EN != 0) ? CLS_JALR : CLS_BAD;
            default:    c = CLS_BAD;
        endcase
        return c;
    endfunction

    // Control word for the state being entered; decoded fields hold through EXE, MEM and WB.
    function automatic ctrlT ctrlFor(input stateT st, input irFieldsT f);
        ctrlT      c;
        instClassT cls;
        c   = '0;
        cls = classify(f.opcode);
        if (st == EXE || st == MEM || st == WB) begin
            case (cls)
                CLS_R:     c.aluControl = {f.f7b5, f.f3};
                CLS_I: begin
                    c.aluControl = (f.f3 == 3'b101) ? {f.f7b5, f.f3} : {1'b0, f.f3};
                    c.aluSrc2    = 1'b1;
                end
                CLS_IL: begin
                    c.aluSrc2      = 1'b1;
                    c.regWrDataSel = 2'd1;
                end
                CLS_S:     c.aluSrc2 = 1'b1;
                CLS_B:     c.aluControl = {1'b0, f.f3};
                CLS_LUI:   c.regWrDataSel = 2'd2;
                CLS_AUIPC: begin
                    c.aluSrc1 = 1'b1;
                    c.aluSrc2 = 1'b1;
                end
                CLS_JAL: begin
                    c.aluSrc1      = 1'b1;
                    c.aluSrc2      = 1'b1;
                    c.regWrDataSel = 2'd3;
                end
                CLS_JALR: begin
                    c.aluSrc2      = 1'b1;
                    c.regWrDataSel = 2'd3;
                end
                default: ;
            endcase
        end
        case (st)
            FETCH: c.irEn = 1'b1;
            EXE: begin
                c.branch = (cls == CLS_B);
                c.jal    = (cls == CLS_JAL);
                c.jalr   = (cls == CLS_JALR);
                c.pcEn   = (cls == CLS_B);
            end
            MEM: begin
                c.dataRdEn = (cls == CLS_IL);
                c.dataWrEn = (cls == CLS_S);
                c.pcEn     = (MEM_HANDSHAKE == 0) && (cls == CLS_S);
            end
            WB: begin
                c.wrEn = 1'b1;
                c.pcEn = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

    stateT            state;
    stateT            nextState;
    logic [31:0]      ir;
    logic [31:0]      nextIr;
    irFieldsT         nextFields;
    instClassT        cls;
    ctrlT             ctrl;
    logic             illegal;
    logic [CNT_W-1:0] retired;
    logic             memDone;
    logic             storeAck;
    logic             pcEn;

    assign cls        = classify(ir[6:0]);
    assign nextFields = {nextIr[30], nextIr[14:12], nextIr[6:0]};
    assign memDone    = (MEM_HANDSHAKE == 0) || bus.iMem_Ready;

    // With the handshake the completing store cycle is only known from iMem_Ready
    // in that same cycle, so its PC strobe cannot come from the registered word.
    assign storeAck = (MEM_HANDSHAKE != 0) && (state == MEM) && (cls == CLS_S) && bus.iMem_Ready;
    assign pcEn     = ctrl.pcEn | storeAck;

    always_comb begin
        nextState = state;
        nextIr    = ir;
        case (state)
            FETCH: begin
                nextState = DECODE;
                nextIr    = bus.iInst_Code;
            end
            DECODE: nextState = (cls == CLS_BAD) ? TRAP : EXE;
            EXE: begin
                if (cls == CLS_B)                        nextState = FETCH;
                else if (cls == CLS_S || cls == CLS_IL)  nextState = MEM;
                else                                     nextState = WB;
            end
            MEM:  if (memDone) nextState = (cls == CLS_IL) ? WB : FETCH;
            WB:   nextState = FETCH;
            TRAP: nextState = TRAP;
            default: nextState = FETCH;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state   <= FETCH;
            ir      <= '0;
            ctrl    <= ctrlFor(FETCH, '0);
            illegal <= 1'b0;
            retired <= '0;
        end else begin
            state   <= nextState;
            ir      <= nextIr;
            ctrl    <= ctrlFor(nextState, nextFields);
            illegal <= illegal | (nextState == TRAP);
            retired <= retired + CNT_W'(pcEn);
        end
    end

    assign bus.oIR_En         = ctrl.irEn;
    assign bus.oPC_En         = pcEn;
    assign bus.oFunct3        = ir[14:12];
    assign bus.oALU_Control   = ctrl.aluControl;
    assign bus.oRegWrDataSel  = ctrl.regWrDataSel;
    assign bus.oALUSrcMuxSel1 = ctrl.aluSrc1;
    assign bus.oALUSrcMuxSel2 = ctrl.aluSrc2;
    assign bus.oWrEn          = ctrl.wrEn;
    assign bus.oData_WrEn     = ctrl.dataWrEn;
    assign bus.oData_RdEn     = ctrl.dataRdEn;
    assign bus.oBranch        = ctrl.branch;
    assign bus.oJal           = ctrl.jal;
    assign bus.oJalr          = ctrl.jalr;
    assign bus.oIllegal       = illegal;
    assign bus.oRetired       = retired;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: three parameter variants run directed sessions
// against a timeline model built per instruction, plus literal spot checks.
module tb_multicycle_control_unit;

    typedef struct packed {
        logic        irEn;
        logic        pcEn;
        logic [2:0]  f3;
        logic [3:0]  alu;
        logic [1:0]  rws;
        logic        s1;
        logic        s2;
        logic        wr;
        logic        dw;
        logic        dr;
        logic        br;
        logic        jal;
        logic        jalr;
        logic        ill;
        logic [31:0] ret;
    } obsT;

    localparam int NSESS = 14;
    localparam int MAXN  = 32;

    logic        clk;
    logic        rst;
    int unsigned tests = 0;
    int unsigned fails = 0;
    obsT         expTab [3][MAXN];

    // Each session: reset, then the same instruction word is fetched repeatedly.
    logic [31:0] sInst [NSESS] = '{
        32'h002081B3, 32'h0000A283, 32'h0020A223, 32'h00000063, 32'h000000EF,
        32'h402081B3, 32'h4030D093, 32'h123450B7, 32'h00001097, 32'h000080E7,
        32'h00209463, 32'h0000A283, 32'hFFFFFFFF, 32'h002081B3};
    int unsigned sW [NSESS] = '{0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1000, 0, 0};
    int unsigned sN [NSESS] = '{24, 16, 14, 9, 10, 8, 8, 8, 8, 8, 6, 8, 14, 6};

    multicycle_control_unit_if #(.CNT_W(32)) busA ();
    multicycle_control_unit_if #(.CNT_W(2))  busB ();
    multicycle_control_unit_if #(.CNT_W(32)) busC ();

    multicycle_control_unit #(.JUMP_EN(1), .MEM_HANDSHAKE(1), .CNT_W(32)) dutA (
        .iClk(clk), .iRst(rst), .bus(busA));
    multicycle_control_unit #(.JUMP_EN(1), .MEM_HANDSHAKE(0), .CNT_W(2)) dutB (
        .iClk(clk), .iRst(rst), .bus(busB));
    multicycle_control_unit #(.JUMP_EN(0), .MEM_HANDSHAKE(1), .CNT_W(32)) dutC (
        .iClk(clk), .iRst(rst), .bus(busC));

    obsT obsA, obsB, obsC;
    assign obsA = {busA.oIR_En, busA.oPC_En, busA.oFunct3, busA.oALU_Control, busA.oRegWrDataSel,
                   busA.oALUSrcMuxSel1, busA.oALUSrcMuxSel2, busA.oWrEn, busA.oData_WrEn,
                   busA.oData_RdEn, busA.oBranch, busA.oJal, busA.oJalr, busA.oIllegal, busA.oRetired};
    assign obsB = {busB.oIR_En, busB.oPC_En, busB.oFunct3, busB.oALU_Control, busB.oRegWrDataSel,
                   busB.oALUSrcMuxSel1, busB.oALUSrcMuxSel2, busB.oWrEn, busB.oData_WrEn,
                   busB.oData_RdEn, busB.oBranch, busB.oJal, busB.oJalr, busB.oIllegal,
                   30'd0, busB.oRetired};
    assign obsC = {busC.oIR_En, busC.oPC_En, busC.oFunct3, busC.oALU_Control, busC.oRegWrDataSel,
                   busC.oALUSrcMuxSel1, busC.oALUSrcMuxSel2, busC.oWrEn, busC.oData_WrEn,
                   busC.oData_RdEn, busC.oBranch, busC.oJal, busC.oJalr, busC.oIllegal, busC.oRetired};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic put(input int d, inout int unsigned k, input int unsigned n, input obsT e);
        if (k < n) expTab[d][k] = e;
        k++;
    endtask

    // Lays out the cycle-by-cycle output timeline of back-to-back copies of one instruction.
    task automatic buildExpected(input int d, input bit jumpEn, input bit hs, input int unsigned cntW,
                                 input logic [31:0] inst, input int unsigned w, input int unsigned n);
        obsT             base, e;
        int unsigned     k, memLen;
        longint unsigned ret, wrapMod;
        logic [2:0]      prevF3, f3i;
        bit              legal, isB, isS, isL, isJal, isJalr;
        f3i = inst[14:12];
        base = '0;
        legal = 1; isB = 0; isS = 0; isL = 0; isJal = 0; isJalr = 0;
        case (inst[6:0])
            7'h33: base.alu = {inst[30], f3i};
            7'h13: begin base.alu = (f3i == 3'd5) ? {inst[30], f3i} : {1'b0, f3i}; base.s2 = 1; end
            7'h03: begin isL = 1; base.s2 = 1; base.rws = 2'd1; end
            7'h23: begin isS = 1; base.s2 = 1; end
            7'h63: begin isB = 1; base.alu = {1'b0, f3i}; end
            7'h37: base.rws = 2'd2;
            7'h17: begin base.s1 = 1; base.s2 = 1; end
            7'h6F: begin legal = jumpEn; isJal = 1; base.s1 = 1; base.s2 = 1; base.rws = 2'd3; end
            7'h67: begin legal = jumpEn; isJalr = 1; base.s2 = 1; base.rws = 2'd3; end
            default: legal = 0;
        endcase
        base.f3 = f3i;
        wrapMod = 64'd1 << cntW;
        ret = 0; prevF3 = 3'd0; k = 0;
        memLen = hs ? w + 1 : 1;
        while (k < n) begin
            e = '0; e.irEn = 1; e.f3 = prevF3; e.ret = ret[31:0];
            put(d, k, n, e);
            e = '0; e.f3 = f3i; e.ret = ret[31:0];
            put(d, k, n, e);
            if (!legal) begin
                e.ill = 1;
                while (k < n) put(d, k, n, e);
            end else begin
                e = base; e.ret = ret[31:0];
                e.br = isB; e.jal = isJal; e.jalr = isJalr; e.pcEn = isB;
                put(d, k, n, e);
                if (isB) ret = (ret + 1) % wrapMod;
                for (int unsigned m = 0; (isS || isL) && m < memLen && k < n; m++) begin
                    e = base; e.ret = ret[31:0];
                    e.dr = isL; e.dw = isS; e.pcEn = isS && (m == memLen - 1);
                    put(d, k, n, e);
                end
                if (isS) ret = (ret + 1) % wrapMod;
                if (!isB && !isS) begin
                    e = base; e.ret = ret[31:0]; e.wr = 1; e.pcEn = 1;
                    put(d, k, n, e);
                    ret = (ret + 1) % wrapMod;
                end
                prevF3 = f3i;
            end
        end
    endtask

    // Memory model: asserts ready once a strobe has been held for w earlier cycles.
    task automatic respond(input logic strobe, input int unsigned w, inout int unsigned cnt,
                           output logic rdy);
        if (strobe) begin
            rdy = (cnt >= w);
            cnt++;
        end else begin
            rdy = 1'b0;
            cnt = 0;
        end
    endtask

    initial begin
        int unsigned waitA, waitB, waitC;
        int unsigned rdA, wrB;
        rst = 1'b1;
        for (int s = 0; s < NSESS; s++) begin
            rst = 1'b1;
            busA.iInst_Code = sInst[s];
            busB.iInst_Code = sInst[s];
            busC.iInst_Code = sInst[s];
            busA.iMem_Ready = 1'b0;
            busB.iMem_Ready = 1'b0;
            busC.iMem_Ready = 1'b0;
            buildExpected(0, 1, 1, 32, sInst[s], sW[s], sN[s]);
            buildExpected(1, 1, 0, 2,  sInst[s], sW[s], sN[s]);
            buildExpected(2, 0, 1, 32, sInst[s], sW[s], sN[s]);
            @(posedge clk);
            #1;
            rst = 1'b0;
            waitA = 0; waitB = 0; waitC = 0; rdA = 0; wrB = 0;
            for (int unsigned k = 0; k < sN[s]; k++) begin
                @(negedge clk);
                respond(busA.oData_RdEn | busA.oData_WrEn, sW[s], waitA, busA.iMem_Ready);
                respond(busB.oData_RdEn | busB.oData_WrEn, sW[s], waitB, busB.iMem_Ready);
                respond(busC.oData_RdEn | busC.oData_WrEn, sW[s], waitC, busC.iMem_Ready);
                #1;
                check($sformatf("obsA s%0d c%0d", s, k), 64'(obsA), 64'(expTab[0][k]));
                check($sformatf("obsB s%0d c%0d", s, k), 64'(obsB), 64'(expTab[1][k]));
                check($sformatf("obsC s%0d c%0d", s, k), 64'(obsC), 64'(expTab[2][k]));

                if (s == 0 && k == 0)  check("reset fetch irEn/retired", {busA.oIR_En, busA.oRetired}, {1'b1, 32'd0});
                if (s == 0 && k == 3)  check("add wb wrEn/pcEn/alu", {busA.oWrEn, busA.oPC_En, busA.oALU_Control}, 6'b110000);
                if (s == 0 && k == 4)  check("add retired", busA.oRetired, 1);
                if (s == 0 && k == 16) check("retired wrap", busB.oRetired, 0);
                if (s == 1)            rdA += busA.oData_RdEn;
                if (s == 1 && k == 7)  check("lw rdEn cycles", rdA, 4);
                if (s == 1 && k == 7)  check("lw wb sel", {busA.oWrEn, busA.oRegWrDataSel}, 3'b101);
                if (s == 1 && k == 8)  check("lw next fetch", busA.oIR_En, 1);
                if (s == 2)            wrB += busB.oWrEn;
                if (s == 2 && k == 3)  check("sw mem strobe", {busB.oData_WrEn, busB.oPC_En}, 2'b11);
                if (s == 2 && k == 13) check("sw never wrEn", wrB, 0);
                if (s == 3 && k == 2)  check("beq exe", {busA.oBranch, busA.oPC_En, busA.oALU_Control}, 6'b110000);
                if (s == 3 && k == 3)  check("beq next fetch", busA.oIR_En, 1);
                if (s == 4 && k == 2)  check("jal exe", {busA.oJal, busA.oALUSrcMuxSel1, busA.oALUSrcMuxSel2}, 3'b111);
                if (s == 4 && k == 3)  check("jal wb sel", busA.oRegWrDataSel, 3);
                if (s == 4 && k == 2)  check("jal disabled trap", busC.oIllegal, 1);
                if (s == 12 && k == 12) check("trap held", {busA.oIllegal, busA.oIR_En, busA.oPC_En, busA.oWrEn,
                                                            busA.oData_WrEn, busA.oData_RdEn}, 6'b100000);
                if (s == 13 && k == 0) check("post-trap reset", {busA.oIllegal, busA.oIR_En, busA.oRetired},
                                             {1'b0, 1'b1, 32'd0});
            end
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
